// File: rtl/timed_sig_scheduler.sv
// rtl/timed_sig_scheduler.sv - highway/country traffic-light scheduler with pedestrian walk phase
//
// Purpose:
//   Sequences a highway / country-road intersection through seven phases.
//   The highway rests in green until its minimum green time has elapsed and
//   either a country car or a pedestrian request is waiting. Pedestrian
//   requests are latched and served in an all-red walk phase inserted between
//   the highway and country greens. The country green is held only while cars
//   are present, and never longer than its maximum.
//
// Parameters (all durations in clock cycles, range 1..255):
//   MIN_HWY_GREEN   minimum highway green
//   MAX_CNTRY_GREEN maximum country green
//   Y_TIME          yellow time (both roads)
//   R_TIME          all-red clearance time
//   W_TIME          pedestrian walk time
//
// Ports:
//   clk      in   1  clock, all state changes on the rising edge
//   clear    in   1  synchronous active-high reset
//   x        in   1  country-road car sensor (level)
//   ped_req  in   1  pedestrian button (any pulse width)
//   hwy      out  2  highway lamp   (0=RED, 1=YELLOW, 2=GREEN)
//   cntry    out  2  country lamp   (same encoding)
//   walk     out  1  pedestrian walk lamp
//   phase    out  3  current state code (0..6)

module timed_sig_scheduler #(
    parameter int MIN_HWY_GREEN   = 8,
    parameter int MAX_CNTRY_GREEN = 10,
    parameter int Y_TIME          = 3,
    parameter int R_TIME          = 2,
    parameter int W_TIME          = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_HWY_G   = 3'd0,
        S_HWY_Y   = 3'd1,
        S_RED_A   = 3'd2,
        S_WALK    = 3'd3,
        S_CNTRY_G = 3'd4,
        S_CNTRY_Y = 3'd5,
        S_RED_B   = 3'd6
    } state_t;

    localparam logic [1:0] L_RED    = 2'd0;
    localparam logic [1:0] L_YELLOW = 2'd1;
    localparam logic [1:0] L_GREEN  = 2'd2;

    // Timer reload values: a state entered with DUR-1 that leaves on
    // timer==0 is occupied for exactly DUR cycles.
    localparam logic [7:0] L_LOAD_HWY_G   = 8'(MIN_HWY_GREEN - 1);
    localparam logic [7:0] L_LOAD_CNTRY_G = 8'(MAX_CNTRY_GREEN - 1);
    localparam logic [7:0] L_LOAD_Y       = 8'(Y_TIME - 1);
    localparam logic [7:0] L_LOAD_R       = 8'(R_TIME - 1);
    localparam logic [7:0] L_LOAD_W       = 8'(W_TIME - 1);

    state_t      r_state;
    logic [7:0]  r_timer;
    logic        r_ped_pending;
    logic [1:0]  r_hwy;
    logic [1:0]  r_cntry;
    logic        r_walk;

    state_t      w_next_state;
    logic        w_timer_zero;
    logic        w_entry;
    logic        w_enter_walk;
    logic [7:0]  w_load;
    logic [7:0]  w_next_timer;
    logic        w_next_ped;
    logic [1:0]  w_next_hwy;
    logic [1:0]  w_next_cntry;
    logic        w_next_walk;

    assign w_timer_zero = (r_timer == 8'd0);

    // Next-state selection. Only the registered pending flag is consulted, so
    // a button press in the same cycle a decision is made is carried to the
    // next round rather than changing the decision combinationally.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_HWY_G: begin
                if (w_timer_zero && (x || r_ped_pending)) begin
                    w_next_state = S_HWY_Y;
                end
            end
            S_HWY_Y: begin
                if (w_timer_zero) begin
                    w_next_state = S_RED_A;
                end
            end
            S_RED_A: begin
                if (w_timer_zero) begin
                    w_next_state = r_ped_pending ? S_WALK : S_CNTRY_G;
                end
            end
            S_WALK: begin
                if (w_timer_zero) begin
                    w_next_state = x ? S_CNTRY_G : S_HWY_G;
                end
            end
            S_CNTRY_G: begin
                // Gap-out on no car or max-out on timer, whichever comes first.
                if (!x || w_timer_zero) begin
                    w_next_state = S_CNTRY_Y;
                end
            end
            S_CNTRY_Y: begin
                if (w_timer_zero) begin
                    w_next_state = S_RED_B;
                end
            end
            S_RED_B: begin
                if (w_timer_zero) begin
                    w_next_state = S_HWY_G;
                end
            end
            default: begin
                // Unused code 7 recovers to highway green.
                w_next_state = S_HWY_G;
            end
        endcase
    end

    // A state change (including recovery from the unused code) is an entry
    // and reloads the timer for the state being entered.
    assign w_entry      = (w_next_state != r_state);
    assign w_enter_walk = w_entry && (w_next_state == S_WALK);

    always_comb begin
        w_load = L_LOAD_HWY_G;
        case (w_next_state)
            S_HWY_G:   w_load = L_LOAD_HWY_G;
            S_HWY_Y:   w_load = L_LOAD_Y;
            S_RED_A:   w_load = L_LOAD_R;
            S_WALK:    w_load = L_LOAD_W;
            S_CNTRY_G: w_load = L_LOAD_CNTRY_G;
            S_CNTRY_Y: w_load = L_LOAD_Y;
            S_RED_B:   w_load = L_LOAD_R;
            default:   w_load = L_LOAD_HWY_G;
        endcase
    end

    // Saturating down-counter; holding in highway green leaves it parked at 0.
    assign w_next_timer = w_entry      ? w_load :
                          w_timer_zero ? 8'd0   :
                                         (r_timer - 8'd1);

    // A press arriving on the same edge as the walk entry stays latched so it
    // is served on the following round.
    assign w_next_ped = ped_req | (r_ped_pending & ~w_enter_walk);

    // Lamp decode of the state about to be registered, so the lamp registers
    // always agree with the state register in the same cycle.
    always_comb begin
        w_next_hwy   = L_RED;
        w_next_cntry = L_RED;
        w_next_walk  = 1'b0;
        case (w_next_state)
            S_HWY_G:   w_next_hwy   = L_GREEN;
            S_HWY_Y:   w_next_hwy   = L_YELLOW;
            S_WALK:    w_next_walk  = 1'b1;
            S_CNTRY_G: w_next_cntry = L_GREEN;
            S_CNTRY_Y: w_next_cntry = L_YELLOW;
            default: begin
                w_next_hwy   = L_RED;
                w_next_cntry = L_RED;
                w_next_walk  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= S_HWY_G;
            r_timer       <= L_LOAD_HWY_G;
            r_ped_pending <= 1'b0;
            r_hwy         <= L_GREEN;
            r_cntry       <= L_RED;
            r_walk        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_next_timer;
            r_ped_pending <= w_next_ped;
            r_hwy         <= w_next_hwy;
            r_cntry       <= w_next_cntry;
            r_walk        <= w_next_walk;
        end
    end

    assign hwy   = r_hwy;
    assign cntry = r_cntry;
    assign walk  = r_walk;
    assign phase = r_state;

endmodule

// File: tb/tb_timed_sig_scheduler.sv
// tb/tb_timed_sig_scheduler.sv - self-checking bench for timed_sig_scheduler
module tb_timed_sig_scheduler;

    localparam int MIN_HWY_GREEN   = 8;
    localparam int MAX_CNTRY_GREEN = 10;
    localparam int Y_TIME          = 3;
    localparam int R_TIME          = 2;
    localparam int W_TIME          = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, cycles already spent in it, latched button.
    int m_phase   = 0;
    int m_elapsed = 0;
    bit m_pend    = 1'b0;

    int seq[$];
    int run_ph[$];
    int run_ln[$];

    timed_sig_scheduler #(
        .MIN_HWY_GREEN  (MIN_HWY_GREEN),
        .MAX_CNTRY_GREEN(MAX_CNTRY_GREEN),
        .Y_TIME         (Y_TIME),
        .R_TIME         (R_TIME),
        .W_TIME         (W_TIME)
    ) dut (
        .clk    (clk),
        .clear  (clear),
        .x      (x),
        .ped_req(ped_req),
        .hwy    (hwy),
        .cntry  (cntry),
        .walk   (walk),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int p);
        case (p)
            0: return MIN_HWY_GREEN;
            1: return Y_TIME;
            2: return R_TIME;
            3: return W_TIME;
            4: return MAX_CNTRY_GREEN;
            5: return Y_TIME;
            default: return R_TIME;
        endcase
    endfunction

    // {hwy, cntry, walk, phase} expected for a phase
    function automatic logic [7:0] m_out(input int p);
        logic [1:0] h;
        logic [1:0] c;
        logic       w;
        h = (p == 0) ? 2'd2 : (p == 1) ? 2'd1 : 2'd0;
        c = (p == 4) ? 2'd2 : (p == 5) ? 2'd1 : 2'd0;
        w = (p == 3);
        return {h, c, w, 3'(p)};
    endfunction

    task automatic step(input bit cx, input bit cp, input bit cc);
        int  nxt;
        bit  done;
        x = cx;
        ped_req = cp;
        clear = cc;
        @(posedge clk);
        if (cc) begin
            m_phase = 0;
            m_elapsed = 0;
            m_pend = 1'b0;
        end else begin
            done = (m_elapsed >= dur(m_phase) - 1);
            nxt = m_phase;
            case (m_phase)
                0: if (done && (cx || m_pend)) nxt = 1;
                1: if (done) nxt = 2;
                2: if (done) nxt = m_pend ? 3 : 4;
                3: if (done) nxt = cx ? 4 : 0;
                4: if (!cx || done) nxt = 5;
                5: if (done) nxt = 6;
                default: if (done) nxt = 0;
            endcase
            m_pend = cp || (m_pend && !(nxt == 3 && m_phase != 3));
            m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
            m_phase = nxt;
        end
        #1;
    endtask

    task automatic build_runs();
        run_ph.delete();
        run_ln.delete();
        foreach (seq[i]) begin
            if (run_ph.size() != 0 && run_ph[run_ph.size()-1] == seq[i]) begin
                run_ln[run_ln.size()-1] = run_ln[run_ln.size()-1] + 1;
            end else begin
                run_ph.push_back(seq[i]);
                run_ln.push_back(1);
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1);
            checks++;
            if ({hwy, cntry, walk, phase} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, {2'd2, 2'd0, 1'b0, 3'd0});
            end
        end
        cnt = 1;
        for (int i = 0; i < 20 && phase == 3'd0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            if (phase == 3'd0) cnt++;
        end
        checks++;
        if (cnt !== 8 || phase !== 3'd1) begin
            errors++;
            $display("FAIL reset_hwy_g_len: got len=%0d phase=%0d expected len=8 phase=1", cnt, phase);
        end
    endtask

    task automatic test_defaults();
        int exp_ph[7] = '{0, 1, 2, 4, 5, 6, 0};
        int exp_ln[6] = '{8, 3, 2, 10, 3, 2};
        step(1'b1, 1'b0, 1'b1);
        seq.delete();
        seq.push_back(int'(phase));
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL defaults_model cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            seq.push_back(int'(phase));
        end
        build_runs();
        checks++;
        if (run_ph.size() < 7) begin
            errors++;
            $display("FAIL defaults_runs: got %0d runs expected at least 7", run_ph.size());
        end else begin
            for (int r = 0; r < 6; r++) begin
                checks++;
                if (run_ph[r] !== exp_ph[r] || run_ln[r] !== exp_ln[r]) begin
                    errors++;
                    $display("FAIL defaults_run%0d: got phase=%0d len=%0d expected phase=%0d len=%0d", r, run_ph[r], run_ln[r], exp_ph[r], exp_ln[r]);
                end
            end
            checks++;
            if (run_ph[6] !== exp_ph[6]) begin
                errors++;
                $display("FAIL defaults_return: got phase=%0d expected 0", run_ph[6]);
            end
        end
    endtask

    task automatic test_x_response();
        int cg;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL xresp_idle cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
        end
        step(1'b1, 1'b0, 1'b0);
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL xresp_yellow_entry: got phase=%0d expected 1", phase);
        end
        cg = 0;
        for (int i = 0; i < 20; i++) begin
            step(i < 9, 1'b0, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL xresp_model cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            if (cntry == 2'd2) cg++;
        end
        checks++;
        if (cg !== 5) begin
            errors++;
            $display("FAIL xresp_cntry_green_len: got %0d expected 5", cg);
        end
    endtask

    task automatic test_ped_walk();
        int exp_ph[4] = '{0, 1, 2, 3};
        int exp_ln[4] = '{8, 3, 2, 4};
        int wc;
        step(1'b0, 1'b0, 1'b1);
        seq.delete();
        seq.push_back(int'(phase));
        wc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, i == 1, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL ped_model cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            seq.push_back(int'(phase));
            if (walk) wc++;
        end
        build_runs();
        checks++;
        if (run_ph.size() != 5) begin
            errors++;
            $display("FAIL ped_runs: got %0d runs expected 5", run_ph.size());
        end else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (run_ph[r] !== exp_ph[r] || run_ln[r] !== exp_ln[r]) begin
                    errors++;
                    $display("FAIL ped_run%0d: got phase=%0d len=%0d expected phase=%0d len=%0d", r, run_ph[r], run_ln[r], exp_ph[r], exp_ln[r]);
                end
            end
            checks++;
            if (run_ph[4] !== 0 || run_ln[4] !== 24) begin
                errors++;
                $display("FAIL ped_after_walk: got phase=%0d len=%0d expected phase=0 len=24", run_ph[4], run_ln[4]);
            end
        end
        checks++;
        if (wc !== 4) begin
            errors++;
            $display("FAIL ped_walk_len: got %0d expected 4", wc);
        end
    endtask

    task automatic test_back_to_back();
        bit pulsed;
        bit p;
        bit prev_walk;
        int walk_runs;
        step(1'b1, 1'b0, 1'b1);
        pulsed = 1'b0;
        prev_walk = 1'b0;
        walk_runs = 0;
        for (int i = 0; i < 60; i++) begin
            p = (i == 0);
            if (phase == 3'd3 && !pulsed) begin
                p = 1'b1;
                pulsed = 1'b1;
            end
            step(1'b1, p, 1'b0);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL b2b_model cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            if (walk && !prev_walk) walk_runs++;
            prev_walk = walk;
        end
        checks++;
        if (walk_runs !== 2) begin
            errors++;
            $display("FAIL b2b_walk_runs: got %0d expected 2", walk_runs);
        end
    endtask

    task automatic test_clear_mid();
        int c4;
        int cnt;
        step(1'b1, 1'b0, 1'b1);
        c4 = 0;
        for (int i = 0; i < 40 && c4 < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (phase == 3'd4) c4++;
        end
        checks++;
        if (c4 !== 5) begin
            errors++;
            $display("FAIL clrmid_reach: got %0d cntry_g cycles expected 5", c4);
        end
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if ({hwy, cntry, walk, phase} !== {2'd2, 2'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clrmid_state: got %h expected %h", {hwy, cntry, walk, phase}, {2'd2, 2'd0, 1'b0, 3'd0});
        end
        cnt = 1;
        for (int i = 0; i < 20 && phase == 3'd0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (phase == 3'd0) cnt++;
        end
        checks++;
        if (cnt !== 8) begin
            errors++;
            $display("FAIL clrmid_hwy_g_len: got %0d expected 8", cnt);
        end
    endtask

    task automatic test_random();
        bit rx;
        bit rp;
        bit rc;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            rx = ($urandom_range(0, 99) < 60);
            rp = ($urandom_range(0, 99) < 4);
            rc = ($urandom_range(0, 299) == 0);
            step(rx, rp, rc);
            checks++;
            if ({hwy, cntry, walk, phase} !== m_out(m_phase)) begin
                errors++;
                $display("FAIL random_model cyc%0d: got %h expected %h", i, {hwy, cntry, walk, phase}, m_out(m_phase));
            end
            checks++;
            if (hwy != 2'd0 && cntry != 2'd0) begin
                errors++;
                $display("FAIL random_conflict cyc%0d: got hwy=%0d cntry=%0d expected one RED", i, hwy, cntry);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_x_response();
        test_ped_walk();
        test_back_to_back();
        test_clear_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timed_sig_scheduler.md
TIMED_SIG_SCHEDULER -- requirements
Module: timed_sig_scheduler

Interface
REQ-001 Parameter MIN_HWY_GREEN, default 8: minimum highway-green duration in cycles, range 1..255.
REQ-002 Parameter MAX_CNTRY_GREEN, default 10: maximum country-green duration in cycles, range 1..255.
REQ-003 Parameter Y_TIME, default 3: yellow duration in cycles, range 1..255.
REQ-004 Parameter R_TIME, default 2: all-red clearance duration in cycles, range 1..255.
REQ-005 Parameter W_TIME, default 4: pedestrian walk duration in cycles, range 1..255.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 clear  input  1  synchronous active-high reset, sampled on rising clk.
REQ-008 x  input  1  country-road car sensor, level-sensitive.
REQ-009 ped_req  input  1  pedestrian button, any width of pulse.
REQ-010 hwy  output  2  highway light: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
REQ-011 cntry  output  2  country light, same encoding.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 phase  output  3  current state code, per REQ-015.

Function
REQ-014 All outputs shall be registered Moore decodes of the state register; no combinational path from any input to any output.
REQ-015 States and codes: HWY_G=0, HWY_Y=1, RED_A=2, WALK=3, CNTRY_G=4, CNTRY_Y=5, RED_B=6; code 7 is illegal and shall go to HWY_G on the next edge.
REQ-016 Lights per state: HWY_G hwy=GREEN/cntry=RED; HWY_Y hwy=YELLOW/cntry=RED; CNTRY_G hwy=RED/cntry=GREEN; CNTRY_Y hwy=RED/cntry=YELLOW; RED_A, WALK, RED_B both RED; walk=1 only in WALK.
REQ-017 8-bit down-counter timer: loaded with DUR-1 on every state entry, decremented while nonzero, saturates at 0; a state whose exit needs only timer==0 lasts exactly DUR cycles.
REQ-018 HWY_G (DUR=MIN_HWY_GREEN): exit to HWY_Y when timer==0 and (x==1 or ped_pending==1); else hold indefinitely.
REQ-019 HWY_Y (DUR=Y_TIME) -> RED_A; RED_A (DUR=R_TIME) -> WALK if ped_pending else CNTRY_G.
REQ-020 WALK (DUR=W_TIME) -> CNTRY_G if x==1 on the exit cycle, else HWY_G.
REQ-021 CNTRY_G (DUR=MAX_CNTRY_GREEN): exit to CNTRY_Y on the first cycle x==0 or timer==0, whichever first; minimum 1 cycle.
REQ-022 CNTRY_Y (DUR=Y_TIME) -> RED_B; RED_B (DUR=R_TIME) -> HWY_G.
REQ-023 ped_pending: set on any cycle ped_req==1; cleared on the edge entering WALK; simultaneous set and clear shall leave it set.
REQ-024 x and ped_req shall have no effect on timer value; hwy and cntry shall never both be non-RED.

Reset
REQ-025 While clear==1 at a rising edge: state=HWY_G, timer=MIN_HWY_GREEN-1, ped_pending=0, hwy=GREEN, cntry=RED, walk=0, phase=0.
REQ-026 clear shall override all inputs and take effect from any state, including mid-timer; no other reset exists.

Verification
REQ-027 clear=1 for 5 cycles with x=1, ped_req=1 -> hwy=2, cntry=0, walk=0, phase=0 throughout; after release, HWY_G holds 8 cycles then exits on x.
REQ-028 Defaults, x=1 held from reset release -> hwy GREEN 8, YELLOW 3, all-red 2, cntry GREEN exactly 10 (max timeout), cntry YELLOW 3, all-red 2, then hwy GREEN.
REQ-029 x=0 for 20 cycles then x=1 for 10 cycles -> HWY_Y entered on the edge after x rises; cntry GREEN until the cycle after x falls; then CNTRY_Y, RED_B, HWY_G.
REQ-030 x=0, one-cycle ped_req at cycle 2 -> hwy GREEN 8, YELLOW 3, RED_A 2, walk=1 for exactly 4 cycles, then HWY_G; ped_pending=0 after.
REQ-031 ped_req and x=1 together -> sequence HWY_Y, RED_A, WALK (4 cycles), CNTRY_G; second ped_req during WALK -> served again on next cycle round.
REQ-032 clear=1 for 1 cycle during CNTRY_G timer=5 -> next edge hwy=GREEN, cntry=RED, phase=0, and HWY_G lasts full 8 cycles.
